song_sequencer: RTL and testbench
=================================

Name: song_sequencer

Overview:
Autoplay controller that drives the piano's square-wave buzzer note generator. It steps through a song stored in an external synchronous ROM. For each entry it presents a note code (1-7 = do..si, 0 = rest) and the buzzer enable for a duration measured in beats. It inserts a short silent articulation gap between notes and supports start, stop, pause and loop. It sits between the mode/top FSM and the buzzer note generator, which consumes note[3:0] and enable directly.

Parameters:
BEAT_CYCLES, 25_000_000, clk cycles per beat (0.25 s at 100 MHz); must be >= GAP_CYCLES+1
GAP_CYCLES, 2_500_000, silent cycles with enable=0 appended after every entry
ADDR_W, 6, ROM address width; song holds at most 2**ADDR_W entries
CNT_W, 32, width of the beat/gap cycle counter

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  1-cycle pulse; begins playback at address 0 (ignored unless IDLE)
stop  in  1  level or pulse; aborts playback to IDLE, highest priority after rst
pause  in  1  level; while high, timing freezes and output is silenced
loop_en  in  1  sampled at end marker; 1 = restart at address 0
rom_addr  out  ADDR_W  ROM read address
rom_data  in  8  [7:4] note code, [3:0] duration in beats; data valid 1 cycle after rom_addr
note  out  4  note code to the buzzer
enable  out  1  buzzer enable
busy  out  1  high in every state except IDLE
done  out  1  1-cycle pulse when a non-looping song ends
song_idx  out  ADDR_W  address of the entry currently sounding

Behaviour:
- Reset values: state=IDLE; rom_addr=0, note=0, enable=0, busy=0, done=0, song_idx=0, counters=0.
- States: IDLE, FETCH, LOAD, PLAY, GAP, PAUSED.
- IDLE: start -> FETCH with rom_addr=0.
- FETCH: rom_addr is stable. Next state is LOAD (1-cycle ROM latency).
- LOAD: latch rom_data.
  - dur==0 is the end marker. If loop_en=1, go to FETCH with rom_addr=0. Otherwise go to IDLE and pulse done.
  - Else load beat_cnt=dur, cyc_cnt=0, note=rom_data[7:4], song_idx=rom_addr, and go to PLAY.
- PLAY:
  - enable=1 iff note!=0; a note-0 entry is a rest.
  - cyc_cnt increments each cycle. On cyc_cnt==BEAT_CYCLES-1 it wraps to 0 and beat_cnt decrements.
  - When beat_cnt==1 and cyc_cnt==BEAT_CYCLES-1-GAP_CYCLES, go to GAP. The gap is taken from the last beat, so entry length is exactly dur*BEAT_CYCLES cycles.
- GAP: enable=0, note held. After GAP_CYCLES cycles, rom_addr+1 -> FETCH.
  - rom_addr wraps to 0 after 2**ADDR_W-1 with no end marker; treat as loop.
- Sound latency: first enable=1 appears 2 cycles after start (FETCH, LOAD).
- pause=1 in PLAY or GAP -> PAUSED.
  - PAUSED: enable=0, all counters frozen, note held.
  - pause=0 returns to the saved state and resumes the count where it stopped.
- stop has priority over pause and start. Any state -> IDLE next cycle with the reset output values; done is not pulsed.
- Simultaneous start+stop in IDLE: stay IDLE.
- rst mid-song: identical to power-up reset.
- done is never asserted while busy remains 1.

Optional Feature:
TEMPO_CTRL_EN:
- Defined: adds input tempo[1:0], sampled in LOAD per entry.
  - 0 = beat length BEAT_CYCLES
  - 1 = BEAT_CYCLES/2 (fast)
  - 2 = 2*BEAT_CYCLES (slow)
  - 3 = treated as 0
  - GAP_CYCLES is unchanged.
- Undefined: the port is absent and beat length is fixed at BEAT_CYCLES.

Decomposition:
- Shared package piano_pkg holds:
  - note code constants NOTE_REST=0, NOTE_DO=1 .. NOTE_SI=7
  - ROM field positions (NOTE_MSB=7, NOTE_LSB=4, DUR_MSB=3, DUR_LSB=0)
  - state enum seq_state_t
- One natural sub-module: beat_timer, the cycle/beat down-counter with a freeze input and tick/last-beat outputs. The FSM stays in song_sequencer.

Test Plan:
- Bench setup: BEAT_CYCLES=10, GAP_CYCLES=2, ROM = {0x12, 0x31, 0x02, 0x00}.
- Basic play:
  - start -> note=1, enable=1 for 18 cycles, then 2 cycles enable=0.
  - note=3 for 8 cycles + 2 gap.
  - rest 18 cycles + 2 gap.
  - Then done pulses once; busy falls the same cycle.
- Loop: loop_en=1 -> after the end marker, rom_addr returns to 0 and note=1 restarts 2 cycles later; done never pulses.
- Pause: pause high for 7 cycles at cycle 5 of note 1 -> enable=0 during the pause; total note-1 enable time is still 18 cycles.
- Stop: stop mid-note 3 -> next cycle enable=0, note=0, busy=0, done=0; a later start replays from address 0.
- Reset and races: rst during GAP -> all outputs return to reset values next cycle. start+stop together in IDLE -> remains IDLE.
- TEMPO_CTRL_EN build: tempo=1 -> note 1 enable lasts 8 cycles (2*5-2).

Source files
------------

// File: rtl/piano_pkg.sv
// Shared definitions for the piano autoplay path: note codes, song ROM
// field positions and the sequencer state encoding.
package piano_pkg;

  localparam logic [3:0] NOTE_REST = 4'd0;
  localparam logic [3:0] NOTE_DO   = 4'd1;
  localparam logic [3:0] NOTE_RE   = 4'd2;
  localparam logic [3:0] NOTE_MI   = 4'd3;
  localparam logic [3:0] NOTE_FA   = 4'd4;
  localparam logic [3:0] NOTE_SO   = 4'd5;
  localparam logic [3:0] NOTE_LA   = 4'd6;
  localparam logic [3:0] NOTE_SI   = 4'd7;

  // Song ROM entry layout: [7:4] note code, [3:0] duration in beats
  localparam int NOTE_MSB = 7;
  localparam int NOTE_LSB = 4;
  localparam int DUR_MSB  = 3;
  localparam int DUR_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_LOAD,
    ST_PLAY,
    ST_GAP,
    ST_PAUSED
  } seq_state_t;

endpackage

// File: rtl/beat_timer.sv
// Cycle/beat down-counter for one song entry. The cycle counter runs
// 0..beat_len-1 and each wrap consumes one beat; the articulation gap is
// carved out of the tail of the final beat so an entry stays dur beats long.
module beat_timer
  import piano_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int GAP_CYCLES = 2_500_000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [3:0]       dur,
  input  logic [CNT_W-1:0] beat_len,
  input  logic             freeze,
  output logic             tick,
  output logic             last_beat,
  output logic             gap_start
);

  logic [CNT_W-1:0] cyc_cnt;
  logic [3:0]       beat_cnt;

  // Load a new entry, otherwise advance the cycle count unless frozen
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cyc_cnt  <= '0;
      beat_cnt <= '0;
    end else if (load) begin
      cyc_cnt  <= '0;
      beat_cnt <= dur;
    end else if (!freeze) begin
      if (tick) begin
        cyc_cnt  <= '0;
        beat_cnt <= beat_cnt - 4'd1;
      end else begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
    end
  end

  assign tick      = (cyc_cnt == beat_len - CNT_W'(1));
  assign last_beat = (beat_cnt == 4'd1);
  assign gap_start = last_beat &&
                     (cyc_cnt == beat_len - CNT_W'(GAP_CYCLES) - CNT_W'(1));

endmodule

// File: rtl/song_sequencer.sv
// Autoplay sequencer: walks a song held in an external synchronous ROM and
// drives note/enable for the buzzer note generator, with an articulation
// gap after every entry plus start/stop/pause/loop control.
// Optional build macro TEMPO_CTRL_EN adds a per-entry tempo[1:0] input
// (0/3 = normal, 1 = half beat length, 2 = double beat length).
module song_sequencer
  import piano_pkg::*;
#(
  parameter int BEAT_CYCLES = 25_000_000,
  parameter int GAP_CYCLES  = 2_500_000,
  parameter int ADDR_W      = 6,
  parameter int CNT_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_en,
`ifdef TEMPO_CTRL_EN
  input  logic [1:0]        tempo,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [7:0]        rom_data,
  output logic [3:0]        note,
  output logic              enable,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] song_idx
);

  seq_state_t       state;
  seq_state_t       resume_state;
  logic [CNT_W-1:0] beat_len;
  logic [CNT_W-1:0] entry_beat_len;
  logic [3:0]       rom_note;
  logic [3:0]       rom_dur;
  logic             timer_load;
  logic             timer_freeze;
  logic             tick;
  logic             last_beat;
  logic             gap_start;
  logic             gap_end;

  assign rom_note = rom_data[NOTE_MSB:NOTE_LSB];
  assign rom_dur  = rom_data[DUR_MSB:DUR_LSB];

`ifdef TEMPO_CTRL_EN
  // Pick this entry's beat length from the tempo input
  always_comb begin
    entry_beat_len = CNT_W'(BEAT_CYCLES);
    case (tempo)
      2'd1:    entry_beat_len = CNT_W'(BEAT_CYCLES / 2);
      2'd2:    entry_beat_len = CNT_W'(2 * BEAT_CYCLES);
      default: entry_beat_len = CNT_W'(BEAT_CYCLES);
    endcase
  end
`else
  assign entry_beat_len = CNT_W'(BEAT_CYCLES);
`endif

  // Timing only advances while sounding or in the gap, and never while paused
  assign timer_load   = (state == ST_LOAD) && (rom_dur != 4'd0);
  assign timer_freeze = !(((state == ST_PLAY) || (state == ST_GAP)) && !pause);
  assign gap_end      = last_beat && tick;

  beat_timer #(
    .CNT_W      (CNT_W),
    .GAP_CYCLES (GAP_CYCLES)
  ) u_beat_timer (
    .clk       (clk),
    .rst       (rst),
    .clear     (stop),
    .load      (timer_load),
    .dur       (rom_dur),
    .beat_len  (beat_len),
    .freeze    (timer_freeze),
    .tick      (tick),
    .last_beat (last_beat),
    .gap_start (gap_start)
  );

  // Playback FSM; stop behaves like reset on outputs but never pulses done
  always_ff @(posedge clk) begin
    if (rst || stop) begin
      state        <= ST_IDLE;
      resume_state <= ST_IDLE;
      rom_addr     <= '0;
      note         <= NOTE_REST;
      song_idx     <= '0;
      done         <= 1'b0;
      beat_len     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            rom_addr <= '0;
            state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (rom_dur == 4'd0) begin
            rom_addr <= '0;
            if (loop_en) begin
              state <= ST_FETCH;
            end else begin
              state    <= ST_IDLE;
              done     <= 1'b1;
              note     <= NOTE_REST;
              song_idx <= '0;
            end
          end else begin
            note     <= rom_note;
            song_idx <= rom_addr;
            beat_len <= entry_beat_len;
            state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (pause) begin
            resume_state <= ST_PLAY;
            state        <= ST_PAUSED;
          end else if (gap_start) begin
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (pause) begin
            resume_state <= ST_GAP;
            state        <= ST_PAUSED;
          end else if (gap_end) begin
            rom_addr <= rom_addr + ADDR_W'(1);
            state    <= ST_FETCH;
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state <= resume_state;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign enable = (state == ST_PLAY) && (note != NOTE_REST) && !pause;

endmodule

// File: tb/tb_song_sequencer.sv
// Self-checking bench for song_sequencer. A behavioural model expands the
// song ROM into a per-cycle list of expected outputs; pause, stop and reset
// events are applied to that list as edits before the run is replayed.
// Build with TEMPO_CTRL_EN defined to also exercise the tempo input.
module tb_song_sequencer;

  localparam int BEAT = 10;
  localparam int GAP  = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       loop_en;
  logic [5:0] rom_addr;
  logic [7:0] rom_data;
  logic [3:0] note;
  logic       enable;
  logic       busy;
  logic       done;
  logic [5:0] song_idx;
`ifdef TEMPO_CTRL_EN
  logic [1:0] tempo;
`endif

  logic [7:0]  rom [0:63];
  logic [18:0] exp_q [$];
  int          compared = 0;
  int          mismatched = 0;
  int          noteEnCount;
  int          donePulses;
  logic [3:0]  countNote;

  song_sequencer #(
    .BEAT_CYCLES (BEAT),
    .GAP_CYCLES  (GAP),
    .ADDR_W      (6),
    .CNT_W       (32)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .loop_en  (loop_en),
`ifdef TEMPO_CTRL_EN
    .tempo    (tempo),
`endif
    .rom_addr (rom_addr),
    .rom_data (rom_data),
    .note     (note),
    .enable   (enable),
    .busy     (busy),
    .done     (done),
    .song_idx (song_idx)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM, one cycle of read latency
  always @(posedge clk) rom_data <= rom[rom_addr];

  function automatic logic [18:0] pk(input logic b, input logic d, input logic e,
                                     input logic [3:0] n, input logic [5:0] idx,
                                     input logic [5:0] addr);
    return {b, d, e, n, idx, addr};
  endfunction

  // Expand the ROM song into expected per-cycle outputs, starting the cycle after start
  task automatic buildSong(input bit loopOn, input int beatLen, input int maxCycles);
    logic [5:0] addr;
    logic [5:0] curIdx;
    logic [3:0] curNote;
    logic [3:0] n;
    logic [3:0] dur;
    bit         finished;
    exp_q.delete();
    addr = 6'd0;
    curIdx = 6'd0;
    curNote = 4'd0;
    finished = 1'b0;
    while (!finished && exp_q.size() < maxCycles) begin
      repeat (2) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, curNote, curIdx, addr));
      n = rom[addr][7:4];
      dur = rom[addr][3:0];
      if (dur == 4'd0) begin
        if (loopOn) begin
          addr = 6'd0;
        end else begin
          exp_q.push_back(pk(1'b0, 1'b1, 1'b0, 4'd0, 6'd0, 6'd0));
          exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 6'd0));
          finished = 1'b1;
        end
      end else begin
        curNote = n;
        curIdx = addr;
        repeat (int'(dur) * beatLen - GAP) exp_q.push_back(pk(1'b1, 1'b0, n != 4'd0, n, addr, addr));
        repeat (GAP) exp_q.push_back(pk(1'b1, 1'b0, 1'b0, n, addr, addr));
        addr = addr + 6'd1;
      end
    end
  endtask

  // A pause held for len cycles costs len+1 silent cycles, then playback resumes unchanged
  task automatic insertPause(input int at, input int len);
    logic [18:0] v;
    v = exp_q[at];
    v[16] = 1'b0;
    for (int k = 0; k <= len; k++) exp_q.insert(at, v);
  endtask

  // A stop or reset seen in cycle 'at' leaves the sequencer idle from the next cycle
  task automatic cutAt(input int at);
    exp_q = exp_q[0:at];
    repeat (2) exp_q.push_back(pk(1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 6'd0));
  endtask

  task automatic checkOutput(input string tag, input int cyc, input logic [18:0] expv);
    logic [18:0] obs;
    obs = {busy, done, enable, note, song_idx, rom_addr};
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("[TB] FAIL %s cycle %0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic checkScalar(input string tag, input int obs, input int expv);
    compared++;
    assert (obs == expv) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Pulse start, then replay the expected list cycle by cycle with pause/stop/rst events
  task automatic applyStimulus(input string tag, input int pauseAt, input int pauseLen,
                               input int stopAt, input int rstAt);
    noteEnCount = 0;
    donePulses = 0;
    start = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      pause = (i >= pauseAt) && (i < pauseAt + pauseLen);
      stop = (i == stopAt);
      rst = (i == rstAt);
      @(negedge clk);
      checkOutput(tag, i, exp_q[i]);
      if (enable && note == countNote) noteEnCount++;
      if (done) donePulses++;
    end
    pause = 1'b0;
    stop = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic loadBasicRom();
    for (int k = 0; k < 64; k++) rom[k] = 8'h00;
    rom[0] = 8'h12;
    rom[1] = 8'h31;
    rom[2] = 8'h02;
    rom[3] = 8'h00;
  endtask

  initial begin
    int songLen;
    int pAt;
    int pLen;
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    pause = 1'b0;
    loop_en = 1'b0;
    countNote = 4'd1;
`ifdef TEMPO_CTRL_EN
    tempo = 2'd0;
`endif
    loadBasicRom();

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset", 0, pk(1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 6'd0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    $display("[TB] basic play");
    buildSong(1'b0, BEAT, 1000);
    applyStimulus("basic", -1, 0, -1, -1);
    checkScalar("basic_note1_on", noteEnCount, 18);
    checkScalar("basic_done_pulses", donePulses, 1);

    $display("[TB] loop");
    loop_en = 1'b1;
    buildSong(1'b1, BEAT, 90);
    cutAt(88);
    applyStimulus("loop", -1, 0, 88, -1);
    loop_en = 1'b0;
    checkScalar("loop_done_pulses", donePulses, 0);
    checkScalar("loop_note1_on", noteEnCount, 36);

    $display("[TB] pause");
    buildSong(1'b0, BEAT, 1000);
    insertPause(7, 7);
    applyStimulus("pause", 7, 7, -1, -1);
    checkScalar("pause_note1_on", noteEnCount, 18);

    $display("[TB] stop mid note 3 then replay");
    buildSong(1'b0, BEAT, 1000);
    cutAt(27);
    applyStimulus("stop", -1, 0, 27, -1);
    checkScalar("stop_done_pulses", donePulses, 0);
    buildSong(1'b0, BEAT, 1000);
    applyStimulus("replay", -1, 0, -1, -1);
    checkScalar("replay_done_pulses", donePulses, 1);

    $display("[TB] reset during gap");
    buildSong(1'b0, BEAT, 1000);
    cutAt(20);
    applyStimulus("rst_gap", -1, 0, -1, 20);

    $display("[TB] start with stop in idle");
    start = 1'b1;
    stop = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("start_stop_idle", k, pk(1'b0, 1'b0, 1'b0, 4'd0, 6'd0, 6'd0));
      @(posedge clk);
      #1;
    end

    $display("[TB] random songs");
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 64; k++) rom[k] = 8'h00;
      songLen = int'($urandom_range(1, 5));
      for (int k = 0; k < songLen; k++) begin
        rom[k] = {4'($urandom_range(0, 7)), 4'($urandom_range(1, 3))};
      end
      pAt = 2 + int'($urandom_range(0, BEAT - GAP - 1));
      pLen = int'($urandom_range(1, 6));
      buildSong(1'b0, BEAT, 1000);
      insertPause(pAt, pLen);
      applyStimulus("random", pAt, pLen, -1, -1);
      checkScalar("random_done_pulses", donePulses, 1);
    end
    loadBasicRom();

`ifdef TEMPO_CTRL_EN
    $display("[TB] tempo control");
    tempo = 2'd1;
    buildSong(1'b0, BEAT / 2, 1000);
    applyStimulus("tempo_fast", -1, 0, -1, -1);
    checkScalar("tempo_fast_note1_on", noteEnCount, 8);
    tempo = 2'd2;
    buildSong(1'b0, 2 * BEAT, 1000);
    applyStimulus("tempo_slow", -1, 0, -1, -1);
    checkScalar("tempo_slow_note1_on", noteEnCount, 38);
    tempo = 2'd3;
    buildSong(1'b0, BEAT, 1000);
    applyStimulus("tempo_three", -1, 0, -1, -1);
    checkScalar("tempo_three_note1_on", noteEnCount, 18);
    tempo = 2'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
